// File: rtl/reg_file_pkg.sv
// Shared constants and byte-merge helper for the reg_file_sb register file.
package reg_file_pkg;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned REG_V0     = 2;

  // Widest register the merge helper supports; narrower words are zero-extended.
  localparam int unsigned MAX_DATA_W = 128;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  // Replace the bytes of i_old selected by i_be with the matching bytes of i_new.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] i_old,
    input logic [MAX_DATA_W-1:0] i_new,
    input logic [MAX_BE_W-1:0]   i_be
  );
    logic [MAX_DATA_W-1:0] v;
    v = i_old;
    for (int unsigned b = 0; b < MAX_BE_W; b++) begin
      if (i_be[b]) v[b*8 +: 8] = i_new[b*8 +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers reserved by in-flight loads.
// A clear (memory writeback) is applied before a same-cycle reservation.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_rsv_en,
  input  logic [ADDR_W-1:0]     i_rsv_addr,
  input  logic                  i_clr_en,
  input  logic [ADDR_W-1:0]     i_clr_addr,
  output logic [(1<<ADDR_W)-1:0] o_busy,
  output logic [ADDR_W:0]       o_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_count;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  w_count_nxt;
  logic             w_clr;
  logic             w_set;

  // Next busy vector and count: clear first, then reserve.
  always_comb begin
    w_busy_nxt  = r_busy;
    w_count_nxt = r_count;
    w_clr       = i_clr_en && (i_clr_addr != ADDR_W'(REG_ZERO)) && r_busy[i_clr_addr];
    if (w_clr) w_busy_nxt[i_clr_addr] = 1'b0;
    w_set       = i_rsv_en && (i_rsv_addr != ADDR_W'(REG_ZERO)) && !w_busy_nxt[i_rsv_addr];
    if (w_set) w_busy_nxt[i_rsv_addr] = 1'b1;
    case ({w_set, w_clr})
      2'b10:   w_count_nxt = r_count + (ADDR_W+1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_W+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_count = r_count;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with N combinational read ports, an ALU write port, a
// byte-enabled memory write port and a load-reservation scoreboard.
// Optional same-cycle forwarding is enabled by defining REG_BYPASS_EN.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned N_READ = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_READ*ADDR_W-1:0]   rd_addr,
  output logic [N_READ*DATA_W-1:0]   rd_data,
  output logic [N_READ-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic [DATA_W/8-1:0]        wr1_be,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [ADDR_W:0]            rsv_count,
  output logic [DATA_W-1:0]          register_v0
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_same;
  logic [DATA_W-1:0] w_wr1_merged;

  // Merge at the configured word width using the shared package helper.
  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] i_old,
    input logic [DATA_W-1:0] i_new,
    input logic [BE_W-1:0]   i_be
  );
    return DATA_W'(byte_merge(MAX_DATA_W'(i_old), MAX_DATA_W'(i_new), MAX_BE_W'(i_be)));
  endfunction

  // Read view of one register: storage, optionally overlaid with this cycle's writes.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] i_a);
    logic [DATA_W-1:0] v;
    v = (i_a == ADDR_W'(REG_ZERO)) ? '0 : r_regs[i_a];
`ifdef REG_BYPASS_EN
    if (i_a != ADDR_W'(REG_ZERO)) begin
      if (wr0_en && (wr0_addr == i_a))      v = wr0_data;
      else if (wr1_en && (wr1_addr == i_a)) v = merge_w(r_regs[i_a], wr1_data, wr1_be);
    end
`endif
    return v;
  endfunction

  // Busy view of one register; a same-cycle clear hides it when forwarding.
  function automatic logic read_busy(input logic [ADDR_W-1:0] i_a);
    logic b;
    b = w_busy[i_a];
`ifdef REG_BYPASS_EN
    if (wr1_en && (wr1_addr == i_a)) b = 1'b0;
`endif
    return b;
  endfunction

  assign w_wr0_ok     = wr0_en && (wr0_addr != ADDR_W'(REG_ZERO));
  assign w_wr1_ok     = wr1_en && (wr1_addr != ADDR_W'(REG_ZERO));
  assign w_same       = w_wr0_ok && (wr0_addr == wr1_addr);
  assign w_wr1_merged = merge_w(r_regs[wr1_addr], wr1_data, wr1_be);

  // Storage: ALU word write wins over the memory byte write to the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (w_wr0_ok && (wr0_addr == ADDR_W'(i))) begin
          r_regs[i] <= wr0_data;
        end else if (w_wr1_ok && !w_same && (wr1_addr == ADDR_W'(i))) begin
          r_regs[i] <= w_wr1_merged;
        end
      end
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .i_clr_en   (wr1_en),
    .i_clr_addr (wr1_addr),
    .o_busy     (w_busy),
    .o_count    (rsv_count)
  );

  // Read port muxes.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < N_READ; p++) begin
      rd_data[p*DATA_W +: DATA_W] = read_word(rd_addr[p*ADDR_W +: ADDR_W]);
      rd_busy[p]                  = read_busy(rd_addr[p*ADDR_W +: ADDR_W]);
    end
  end

  assign register_v0 = read_word(ADDR_W'(REG_V0));

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic against an array/counter reference model. Honours REG_BYPASS_EN.
module tb_reg_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned BW = DW / 8;

  logic              clk;
  logic              reset_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr0_en;
  logic [AW-1:0]     wr0_addr;
  logic [DW-1:0]     wr0_data;
  logic              wr1_en;
  logic [AW-1:0]     wr1_addr;
  logic [DW-1:0]     wr1_data;
  logic [BW-1:0]     wr1_be;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [AW:0]       rsv_count;
  logic [DW-1:0]     register_v0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [DW-1:0] m_mem  [32];
  bit            m_busy [32];
  int            m_count;

  reg_file_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .N_READ (NR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data),
    .wr1_be      (wr1_be),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .rsv_count   (rsv_count),
    .register_v0 (register_v0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                                input logic [BW-1:0] be);
    logic [DW-1:0] v;
    v = old_v;
    for (int b = 0; b < int'(BW); b++) if (be[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a == 0) ? '0 : m_mem[a];
`ifdef REG_BYPASS_EN
    if (a != 0) begin
      if (wr0_en && wr0_addr == a)      v = wr0_data;
      else if (wr1_en && wr1_addr == a) v = merge_bytes(m_mem[a], wr1_data, wr1_be);
    end
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic b;
    b = m_busy[a];
`ifdef REG_BYPASS_EN
    if (wr1_en && wr1_addr == a) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_count = 0;
  endtask

  // Apply one clock edge's worth of writes and reservations to the model.
  task automatic model_commit();
    if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = merge_bytes(m_mem[wr1_addr], wr1_data, wr1_be);
    if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
    if (wr1_en && wr1_addr != 0 && m_busy[wr1_addr]) begin
      m_busy[wr1_addr] = 1'b0;
      m_count--;
    end
    if (rsv_en && rsv_addr != 0 && !m_busy[rsv_addr]) begin
      m_busy[rsv_addr] = 1'b1;
      m_count++;
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] a;
    for (int p = 0; p < int'(NR); p++) begin
      a = rd_addr[p*AW +: AW];
      check_eq($sformatf("rd_data%0d r%0d", p, a), 64'(rd_data[p*DW +: DW]), 64'(exp_read(a)));
      check_eq($sformatf("rd_busy%0d r%0d", p, a), 64'(rd_busy[p]), 64'(exp_busy(a)));
    end
    check_eq("rsv_count", 64'(rsv_count), 64'(m_count));
    check_eq("register_v0", 64'(register_v0), 64'(exp_read(AW'(2))));
  endtask

  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0; wr1_be = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic do_wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      wr0_en   = ($urandom_range(0, 2) == 0);
      wr0_addr = rnd_addr();
      wr0_data = $urandom;
      wr1_en   = ($urandom_range(0, 2) == 0);
      wr1_addr = rnd_addr();
      wr1_data = $urandom;
      wr1_be   = BW'($urandom);
      rsv_en   = ($urandom_range(0, 1) == 0);
      rsv_addr = rnd_addr();
      set_rd(rnd_addr(), rnd_addr());
      step();
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    rd_addr  = '0;
    wr0_addr = '0; wr0_data = '0;
    wr1_addr = '0; wr1_data = '0;
    rsv_addr = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word ALU write, then a write to r0 that must be dropped.
    do_wr0(5, 32'hDEADBEEF); set_rd(5, 5); step();
    do_wr0(0, 32'h1234);     set_rd(5, 0); step();
    idle(); set_rd(5, 5); #1;
    check_eq("r5 port0", 64'(rd_data[0 +: DW]), 64'h DEADBEEF);
    check_eq("r5 port1", 64'(rd_data[DW +: DW]), 64'h DEADBEEF);
    set_rd(0, 0); #1;
    check_eq("r0 reads 0", 64'(rd_data[0 +: DW]), 64'h0);

    // Byte-enabled memory write.
    do_wr0(7, 32'h11223344); set_rd(7, 0); step();
    idle(); wr1_en = 1'b1; wr1_addr = 7; wr1_data = 32'hAABBCCDD; wr1_be = 4'b0101; step();
    idle(); set_rd(7, 7); #1;
    check_eq("r7 merged", 64'(rd_data[0 +: DW]), 64'h11BB33DD);

    // Reservation sequence.
    idle(); rsv_en = 1'b1; rsv_addr = 3; set_rd(3, 3); step();
    idle(); #1;
    check_eq("r3 busy", 64'(rd_busy[0]), 64'h1);
    check_eq("count after rsv r3", 64'(rsv_count), 64'd1);
    idle(); rsv_en = 1'b1; rsv_addr = 3; step();
    idle(); #1;
    check_eq("count after re-rsv r3", 64'(rsv_count), 64'd1);
    idle(); wr1_en = 1'b1; wr1_addr = 3; wr1_be = '0; step();
    idle(); #1;
    check_eq("r3 cleared", 64'(rd_busy[0]), 64'h0);
    check_eq("count after clr r3", 64'(rsv_count), 64'd0);
    idle(); rsv_en = 1'b1; rsv_addr = 4; set_rd(4, 4); step();
    idle(); rsv_en = 1'b1; rsv_addr = 4; wr1_en = 1'b1; wr1_addr = 4; wr1_data = 32'h0; wr1_be = '0; step();
    idle(); #1;
    check_eq("r4 busy after clr+rsv", 64'(rd_busy[0]), 64'h1);
    check_eq("count after clr+rsv r4", 64'(rsv_count), 64'd1);
    idle(); rsv_en = 1'b1; rsv_addr = 0; set_rd(0, 4); step();
    idle(); #1;
    check_eq("r0 never busy", 64'(rd_busy[0]), 64'h0);
    check_eq("count after rsv r0", 64'(rsv_count), 64'd1);

    // Both write ports hit r9 together.
    idle(); rsv_en = 1'b1; rsv_addr = 9; set_rd(9, 9); step();
    do_wr0(9, 32'h1); wr1_en = 1'b1; wr1_addr = 9; wr1_data = 32'hFFFFFFFF; wr1_be = 4'hF; step();
    idle(); #1;
    check_eq("r9 wr0 wins", 64'(rd_data[0 +: DW]), 64'h1);
    check_eq("r9 rsv cleared", 64'(rd_busy[0]), 64'h0);
    check_eq("count after r9", 64'(rsv_count), 64'd1);

    // Same-cycle visibility of a write to r2.
    do_wr0(2, 32'h55); set_rd(2, 2); #1;
`ifdef REG_BYPASS_EN
    check_eq("r2 same cycle", 64'(rd_data[0 +: DW]), 64'h55);
    check_eq("v0 same cycle", 64'(register_v0), 64'h55);
`else
    check_eq("r2 same cycle", 64'(rd_data[0 +: DW]), 64'h0);
    check_eq("v0 same cycle", 64'(register_v0), 64'h0);
`endif
    step();
    idle(); #1;
    check_eq("r2 next cycle", 64'(rd_data[0 +: DW]), 64'h55);
    check_eq("v0 next cycle", 64'(register_v0), 64'h55);

    random_cycles(500);

    // Asynchronous reset mid-run.
    idle(); set_rd(5, 7);
    reset_n = 1'b0;
    #1;
    check_eq("rst rd_data0", 64'(rd_data[0 +: DW]), 64'h0);
    check_eq("rst rd_data1", 64'(rd_data[DW +: DW]), 64'h0);
    check_eq("rst rd_busy", 64'(rd_busy), 64'h0);
    check_eq("rst rsv_count", 64'(rsv_count), 64'h0);
    check_eq("rst v0", 64'(register_v0), 64'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_wr0(6, 32'hCAFEF00D); rsv_en = 1'b1; rsv_addr = 6; set_rd(6, 2); step();
    idle(); #1;
    check_eq("first edge write r6", 64'(rd_data[0 +: DW]), 64'hCAFEF00D);
    check_eq("first edge rsv r6", 64'(rsv_count), 64'd1);

    random_cycles(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
